// File: rtl/mux_pkg.sv
// Shared definitions for the scan_mux_nxw block.
//   state_t  : auto-scan FSM state encoding (S_IDLE, S_DWELL, S_ADVANCE)
//   clog2_w  : index width helper; never returns less than 1 bit
package mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DWELL   = 2'd1,
    S_ADVANCE = 2'd2
  } state_t;

  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/scan_mux_nxw_if.sv
// Bus bundle between the sample sources / controller and scan_mux_nxw.
//   master : drives din, sel, mode, en_mask, start; observes the outputs
//   slave  : the mux itself; drives dout, ch, dout_valid, sweep_done, busy
interface scan_mux_nxw_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
) ();
  import mux_pkg::*;

  localparam int SW = clog2_w(N_CH);

  logic [N_CH*W-1:0] din;
  logic [SW-1:0]     sel;
  logic              mode;
  logic [N_CH-1:0]   en_mask;
  logic              start;
  logic [W-1:0]      dout;
  logic [SW-1:0]     ch;
  logic              dout_valid;
  logic              sweep_done;
  logic              busy;

  modport master (
    output din, sel, mode, en_mask, start,
    input  dout, ch, dout_valid, sweep_done, busy
  );

  modport slave (
    input  din, sel, mode, en_mask, start,
    output dout, ch, dout_valid, sweep_done, busy
  );

endinterface

// File: rtl/mux_next_en.sv
// Combinational priority finder for the auto-scan pointer.
//   en_mask : channel enables
//   ptr     : current channel index
//   first   : 1 = return the lowest enabled channel, 0 = lowest one above ptr
//   nxt     : resulting index (0 when nothing found)
//   found   : a qualifying enabled channel exists
module mux_next_en #(
  parameter int N_CH = 8,
  parameter int SW   = 3
) (
  input  logic [N_CH-1:0] en_mask,
  input  logic [SW-1:0]   ptr,
  input  logic            first,
  output logic [SW-1:0]   nxt,
  output logic            found
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en_mask[k] && (first || (k > int'(ptr)))) begin
        nxt   = SW'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_mux_nxw.sv
// N-channel, W-bit registered multiplexer with enable mask and auto-scan.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : scan_mux_nxw_if.slave (din/sel/mode/en_mask/start in,
//              dout/ch/dout_valid/sweep_done/busy out, all registered)
// Build option: define SCAN_MUX_CONTINUOUS_EN to restart the sweep at the
// lowest enabled channel on every wrap instead of returning to idle.
module scan_mux_nxw
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  scan_mux_nxw_if.slave  bus
);

  localparam int SW = clog2_w(N_CH);
  localparam int CW = clog2_w(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t        state;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] nxt;
  logic          found;
  logic          first;
  logic          above_none;
  logic          sel_ok;

  logic [W-1:0]  dout_r;
  logic [SW-1:0] ch_r;
  logic          valid_r;
  logic          done_r;
  logic          busy_r;

  assign sel_ok     = int'(bus.sel) < N_CH;
  // No enabled channel above ptr: the next advance is a wrap.
  assign above_none = ((bus.en_mask >> ptr) >> 1) == '0;

`ifdef SCAN_MUX_CONTINUOUS_EN
  assign first = (state == S_IDLE) || above_none;
`else
  assign first = (state == S_IDLE);
`endif

  mux_next_en #(.N_CH(N_CH), .SW(SW)) u_next (
    .en_mask (bus.en_mask),
    .ptr     (ptr),
    .first   (first),
    .nxt     (nxt),
    .found   (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      dout_r  <= '0;
      ch_r    <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (!bus.mode) begin
      // Manual mode overrides any sweep in progress, without a done pulse.
      state   <= S_IDLE;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ch_r    <= bus.sel;
      if (sel_ok) begin
        dout_r  <= bus.din[int'(bus.sel)*W +: W];
        valid_r <= bus.en_mask[bus.sel];
      end else begin
        dout_r  <= '0;
        valid_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          if (bus.start && found) begin
            ptr    <= nxt;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= S_DWELL;
          end
        end
        S_DWELL: begin
          dout_r  <= bus.din[int'(ptr)*W +: W];
          ch_r    <= ptr;
          valid_r <= 1'b1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (above_none) begin
            done_r <= 1'b1;
`ifdef SCAN_MUX_CONTINUOUS_EN
            if (found) begin
              ptr   <= nxt;
              cnt   <= '0;
              state <= S_DWELL;
            end else begin
              busy_r <= 1'b0;
              state  <= S_IDLE;
            end
`else
            busy_r <= 1'b0;
            state  <= S_IDLE;
`endif
          end else begin
            ptr   <= nxt;
            cnt   <= '0;
            state <= S_DWELL;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.ch         = ch_r;
  assign bus.dout_valid = valid_r;
  assign bus.sweep_done = done_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_scan_mux_nxw.sv
module tb_scan_mux_nxw;
  localparam int N_CH  = 8;
  localparam int W     = 1;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  scan_mux_nxw_if #(.N_CH(N_CH), .W(W)) bus ();

  scan_mux_nxw #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] mask;
    logic       exp_dout;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference for one auto sweep: the enabled channels in ascending order,
  // each tracked live for DWELL cycles followed by one hold cycle.
  task automatic run_sweep(input logic [7:0] mask);
    int   order[$];
    logic exp_d;
    logic [7:0] d;
    for (int k = 0; k < N_CH; k++) if (mask[k]) order.push_back(k);
    @(negedge clk);
    bus.mode = 1'b1;
    bus.en_mask = mask;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_busy", bus.busy, (order.size() != 0) ? 1 : 0);
    check("start_valid", bus.dout_valid, 0);
    if (order.size() == 0) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("nomask_busy", bus.busy, 0);
        check("nomask_done", bus.sweep_done, 0);
      end
      return;
    end
    exp_d = 1'b0;
    for (int i = 0; i < order.size(); i++) begin
      for (int c = 0; c < DWELL; c++) begin
        @(negedge clk);
        d = 8'($urandom);
        bus.din = d;
        exp_d = d[order[i]];
        @(posedge clk); #1;
        check("dwell_ch", bus.ch, order[i]);
        check("dwell_dout", bus.dout, exp_d);
        check("dwell_valid", bus.dout_valid, 1);
        check("dwell_busy", bus.busy, 1);
        check("dwell_done", bus.sweep_done, 0);
      end
      @(negedge clk);
      bus.din = 8'($urandom);
      @(posedge clk); #1;
      check("hold_ch", bus.ch, order[i]);
      check("hold_dout", bus.dout, exp_d);
      check("hold_valid", bus.dout_valid, 1);
      check("hold_busy", bus.busy, (i == order.size() - 1) ? 0 : 1);
      check("hold_done", bus.sweep_done, (i == order.size() - 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.dout_valid, 0);
    check("idle_done", bus.sweep_done, 0);
  endtask

  initial begin
    logic [7:0] d, m;
    logic [2:0] s;
    int   cyc;
    bit   seen_done;

    vecs[0] = '{8'b11010011, 3'd0, 8'hFF, 1'b1, 1'b1};
    vecs[1] = '{8'b11010011, 3'd1, 8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'b11010011, 3'd2, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'b11010011, 3'd3, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'b11010011, 3'd4, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'b11010011, 3'd5, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'b11010011, 3'd6, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'b11010011, 3'd7, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'b11010011, 3'd2, 8'hF0, 1'b0, 1'b0};
    vecs[9] = '{8'b11010011, 3'd4, 8'hF0, 1'b1, 1'b1};

    bus.din = '0; bus.sel = '0; bus.mode = 1'b0; bus.en_mask = '0; bus.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_dout", bus.dout, 0);
    check("rst_ch", bus.ch, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_done", bus.sweep_done, 0);
    check("rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Manual table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.din = vecs[i].din; bus.sel = vecs[i].sel; bus.en_mask = vecs[i].mask;
      @(posedge clk); #1;
      check("man_dout", bus.dout, vecs[i].exp_dout);
      check("man_ch", bus.ch, vecs[i].sel);
      check("man_valid", bus.dout_valid, vecs[i].exp_valid);
      check("man_busy", bus.busy, 0);
    end

    // Manual random
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d = 8'($urandom); s = 3'($urandom_range(0, 7)); m = 8'($urandom);
      bus.din = d; bus.sel = s; bus.en_mask = m;
      @(posedge clk); #1;
      check("rman_dout", bus.dout, d[s]);
      check("rman_ch", bus.ch, s);
      check("rman_valid", bus.dout_valid, m[s]);
    end

    // Auto sweeps: plan pattern, empty mask, single top channel, random masks
    run_sweep(8'b10100101);
    run_sweep(8'h00);
    run_sweep(8'h80);
    for (int i = 0; i < 4; i++) run_sweep(8'($urandom_range(1, 255)));

    // Abort by mode 1->0 during channel 2's dwell
    @(negedge clk);
    bus.mode = 1'b1; bus.en_mask = 8'b10100101; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.ch == 3'd2 && bus.dout_valid) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_ch2", (cyc < 30) ? 1 : 0, 1);
    @(negedge clk);
    bus.mode = 1'b0; bus.sel = 3'd3;
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 0);
    check("abort_ch", bus.ch, 3);
    seen_done = bus.sweep_done;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.sweep_done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);

    // Async reset mid-dwell
    @(negedge clk);
    bus.mode = 1'b1; bus.en_mask = 8'hFF; bus.din = 8'hFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", bus.dout_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", bus.dout, 0);
    check("arst_valid", bus.dout_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ch", bus.ch, 0);
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
